// File: rtl/poly_mul_datapath_pkg.sv
// Shared sizing and lane-offset helper for the polynomial multiplier datapath.
// Latency: none (package only).
// Backpressure: none (package only).
package poly_mul_datapath_pkg;

    localparam int N       = 256;            // coefficient lanes
    localparam int W       = 13;             // coefficient width
    localparam int S_WORDS = (N * W) / 64;   // 64-bit words per secret (52)
    localparam int SLICES  = 12;             // 13-bit slices visible in the unpacking buffer

    // Bit offset of lane i inside a packed N*W vector.
    function automatic int lane_off(input int i);
        return W * i;
    endfunction

endpackage

// File: rtl/poly_mul_datapath_secret_load_ctrl.sv
// Streams the secret out of BRAM as S_WORDS consecutive word addresses.
// Latency: s_load qualifies data for address cnt-1 (BRAM read latency of 1 clock).
// Backpressure: none; runs free from reset release and stops after the last word.
module secret_load_ctrl
    import poly_mul_datapath_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    output logic [7:0] s_address,
    output logic       s_load,
    output logic       s_load_done
);

    localparam logic [5:0] LAST = 6'(S_WORDS);

    logic [5:0] cnt;
    logic       cnt_running;

    assign cnt_running = (cnt < LAST);
    assign s_address   = {2'b00, cnt};

    // Address counter runs to S_WORDS and parks there; s_load trails it by one
    // cycle so it lines up with the BRAM output; done latches once the last word
    // has been presented.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt         <= 6'd0;
            s_load      <= 1'b0;
            s_load_done <= 1'b0;
        end else begin
            if (cnt_running) begin
                cnt <= cnt + 6'd1;
            end
            s_load <= cnt_running;
            if ((cnt == LAST) && s_load) begin
                s_load_done <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/poly_mul_datapath.sv
// Secret loader, multiplicand selector and 256 parallel 13-bit MAC lanes.
// Latency: selector and MAC are combinational (0 cycles); loader is registered.
// Backpressure: none; the parent controller registers result on its own schedule.
module poly_mul_datapath
    import poly_mul_datapath_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    output logic [7:0]          s_address,
    output logic                s_load,
    output logic                s_load_done,
    input  logic [SLICES*W-1:0] buf_slice,
    input  logic [W-1:0]        buf_tail,
    input  logic [W-1:0]        buf_coeff16,
    input  logic [3:0]          buffer_counter,
    input  logic                pol_load_coeff4x,
    output logic [W-1:0]        a_coeff,
    input  logic [N*W-1:0]      acc,
    input  logic [N*W-1:0]      secret,
    output logic [N*W-1:0]      result
);

    secret_load_ctrl u_secret_load_ctrl (
        .clk         (clk),
        .rst         (rst),
        .s_address   (s_address),
        .s_load      (s_load),
        .s_load_done (s_load_done)
    );

    // Multiplicand select: 16-bit packed mode bypasses the slice mux; in 13-bit
    // mode counters past the last slice fall back to the buffer tail.
    always_comb begin
        a_coeff = buf_tail;
        if (pol_load_coeff4x) begin
            a_coeff = buf_coeff16;
        end else if (buffer_counter < 4'(SLICES)) begin
            a_coeff = buf_slice[W*buffer_counter +: W];
        end
    end

    // One MAC per lane; truncating to W bits gives the mod 2^13 wrap for free.
    for (genvar i = 0; i < N; i++) begin : g_lane
        localparam int OFF = lane_off(i);
        logic [W-1:0] prod_lo;
        assign prod_lo              = a_coeff * secret[OFF +: W];
        assign result[OFF +: W]     = acc[OFF +: W] + prod_lo;
    end

endmodule

// File: tb/tb_poly_mul_datapath.sv
// Self-checking bench for poly_mul_datapath: loader sequence, reset abort,
// selector modes and MAC lanes against a behavioural model.
module tb_poly_mul_datapath;
    import poly_mul_datapath_pkg::*;

    logic                clk = 1'b0;
    logic                rst;
    logic [7:0]          s_address;
    logic                s_load;
    logic                s_load_done;
    logic [SLICES*W-1:0] buf_slice;
    logic [W-1:0]        buf_tail;
    logic [W-1:0]        buf_coeff16;
    logic [3:0]          buffer_counter;
    logic                pol_load_coeff4x;
    logic [W-1:0]        a_coeff;
    logic [N*W-1:0]      acc;
    logic [N*W-1:0]      secret;
    logic [N*W-1:0]      result;

    always #5 clk = ~clk;

    poly_mul_datapath dut (
        .clk              (clk),
        .rst              (rst),
        .s_address        (s_address),
        .s_load           (s_load),
        .s_load_done      (s_load_done),
        .buf_slice        (buf_slice),
        .buf_tail         (buf_tail),
        .buf_coeff16      (buf_coeff16),
        .buffer_counter   (buffer_counter),
        .pol_load_coeff4x (pol_load_coeff4x),
        .a_coeff          (a_coeff),
        .acc              (acc),
        .secret           (secret),
        .result           (result)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Model state
    int sl[SLICES];
    int tail_v, c16_v, cnt_v, mode_v;
    int acc_v[N];
    int sec_v[N];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Selection rule expressed directly from the mode/counter description.
    function automatic int sel_model();
        if (mode_v != 0) return c16_v;
        if (cnt_v < SLICES) return sl[cnt_v];
        return tail_v;
    endfunction

    task automatic drive();
        for (int k = 0; k < SLICES; k++) buf_slice[k*W +: W] = W'(sl[k]);
        buf_tail         = W'(tail_v);
        buf_coeff16      = W'(c16_v);
        buffer_counter   = 4'(cnt_v);
        pol_load_coeff4x = (mode_v != 0);
        for (int i = 0; i < N; i++) begin
            acc[i*W +: W]    = W'(acc_v[i]);
            secret[i*W +: W] = W'(sec_v[i]);
        end
        #1;
    endtask

    task automatic check_mac(input string tag);
        int a;
        int e;
        a = sel_model();
        check({tag, "_a"}, 32'(a_coeff), 32'(a));
        for (int i = 0; i < N; i++) begin
            e = (acc_v[i] + a * sec_v[i]) % 8192;
            check($sformatf("%s_lane%0d", tag, i), 32'(result[i*W +: W]), 32'(e));
        end
    endtask

    // Called just after reset release between clock edges; k counts edges since release.
    task automatic run_load(input int edges, input string tag);
        int loads;
        int ea;
        loads = 0;
        #1;
        check({tag, "_addr_k0"}, 32'(s_address), 32'd0);
        check({tag, "_load_k0"}, 32'(s_load), 32'd0);
        check({tag, "_done_k0"}, 32'(s_load_done), 32'd0);
        for (int k = 1; k <= edges; k++) begin
            @(posedge clk);
            #1;
            ea = (k < S_WORDS) ? k : S_WORDS;
            check($sformatf("%s_addr_k%0d", tag, k), 32'(s_address), 32'(ea));
            check($sformatf("%s_load_k%0d", tag, k), 32'(s_load), 32'(k <= S_WORDS));
            check($sformatf("%s_done_k%0d", tag, k), 32'(s_load_done), 32'(k > S_WORDS));
            if (s_load) loads++;
        end
        check({tag, "_load_count"}, 32'(loads), 32'(S_WORDS));
    endtask

    initial begin
        rst = 1'b1;
        for (int k = 0; k < SLICES; k++) sl[k] = 0;
        tail_v = 0; c16_v = 0; cnt_v = 0; mode_v = 0;
        for (int i = 0; i < N; i++) begin acc_v[i] = 0; sec_v[i] = 0; end
        drive();

        // Reset state
        #11;
        check("rst_addr", 32'(s_address), 32'd0);
        check("rst_load", 32'(s_load), 32'd0);
        check("rst_done", 32'(s_load_done), 32'd0);

        // Full load sequence plus 200 cycles of sticky done
        @(negedge clk) rst = 1'b0;
        run_load(S_WORDS + 1 + 200, "load");

        // Reset mid-load at address 20
        @(negedge clk) rst = 1'b1;
        @(negedge clk) rst = 1'b0;
        for (int c = 0; c < 60; c++) begin
            @(posedge clk);
            #1;
            if (s_address == 8'd20) break;
        end
        check("mid_addr20_reached", 32'(s_address), 32'd20);
        rst = 1'b1;
        #1;
        check("mid_rst_addr", 32'(s_address), 32'd0);
        check("mid_rst_load", 32'(s_load), 32'd0);
        check("mid_rst_done", 32'(s_load_done), 32'd0);
        @(negedge clk) rst = 1'b0;
        run_load(S_WORDS + 5, "reload");

        // 13-bit selection
        for (int k = 0; k < SLICES; k++) sl[k] = k + 1;
        tail_v = 'h1ABC; mode_v = 0;
        for (int c = 0; c < 16; c++) begin
            cnt_v = c;
            drive();
            check($sformatf("sel13_c%0d", c), 32'(a_coeff), 32'((c < SLICES) ? c + 1 : 'h1ABC));
        end

        // 16-bit selection
        mode_v = 1; c16_v = 'h03FF;
        for (int c = 0; c < 16; c++) begin
            cnt_v = c;
            drive();
            check($sformatf("sel16_c%0d", c), 32'(a_coeff), 32'h03FF);
        end

        // MAC wrap to zero
        mode_v = 1; c16_v = 1;
        for (int i = 0; i < N; i++) begin acc_v[i] = 'h1FFF; sec_v[i] = 1; end
        drive();
        check_mac("wrap0");

        // MAC wrap with large multiplicand
        c16_v = 'h0FFF;
        for (int i = 0; i < N; i++) begin acc_v[i] = i; sec_v[i] = 3; end
        drive();
        check_mac("wrap4093");

        // Lane isolation
        c16_v = 'h1FFF;
        for (int i = 0; i < N; i++) begin acc_v[i] = i; sec_v[i] = 0; end
        sec_v[7] = 'h1FFF;
        drive();
        check_mac("iso");
        check("iso_lane7_direct", 32'(result[7*W +: W]), 32'd8);

        // Randomized selector + MAC
        for (int r = 0; r < 20; r++) begin
            for (int k = 0; k < SLICES; k++) sl[k] = int'($urandom_range(0, 8191));
            tail_v = int'($urandom_range(0, 8191));
            c16_v  = int'($urandom_range(0, 8191));
            cnt_v  = int'($urandom_range(0, 15));
            mode_v = int'($urandom_range(0, 1));
            for (int i = 0; i < N; i++) begin
                acc_v[i] = int'($urandom_range(0, 8191));
                sec_v[i] = int'($urandom_range(0, 8191));
            end
            drive();
            check_mac($sformatf("rnd%0d", r));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
